// File: rtl/ahb_lite_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_slave_pkg
// Shared definitions for the AHB-Lite FIR-filter slave:
//   - htrans encodings
//   - halfword register addresses of the slave's register map
//   - error-response FSM state encoding
//   - byte-lane merge helper used by the write path
// ---------------------------------------------------------------------------
package ahb_lite_slave_pkg;

    // AHB-Lite transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    // Register map (halfword-aligned byte addresses)
    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_RESULT = 4'h2;
    localparam logic [3:0] ADDR_SAMPLE = 4'h4;
    localparam logic [3:0] ADDR_F0     = 4'h6;
    localparam logic [3:0] ADDR_F1     = 4'h8;
    localparam logic [3:0] ADDR_F2     = 4'hA;
    localparam logic [3:0] ADDR_F3     = 4'hC;
    localparam logic [3:0] ADDR_NCS    = 4'hE;

    localparam int NUM_COEF = 4;

    // Error-response sequencer states
    typedef enum logic [1:0] {
        ERR_IDLE = 2'd0,
        ERR_ONE  = 2'd1,
        ERR_TWO  = 2'd2
    } err_state_e;

    // Merge write data into an existing halfword: a halfword access replaces
    // everything, a byte access replaces only the lane picked by haddr[0].
    function automatic logic [15:0] merge_lanes(
        input logic [15:0] old_val,
        input logic [15:0] wdata,
        input logic        size,
        input logic        lane
    );
        logic [15:0] result;
        result = old_val;
        if (size) begin
            result = wdata;
        end else if (lane) begin
            result[15:8] = wdata[15:8];
        end else begin
            result[7:0] = wdata[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/ahb_err_fsm.sv
// ---------------------------------------------------------------------------
// ahb_err_fsm
// Two-cycle AHB ERROR response sequencer: IDLE -> ERR_ONE -> ERR_TWO -> IDLE.
// A new illegal write accepted during ERR_TWO restarts the sequence.
// Ports:
//   clk     in   system clock
//   n_rst   in   asynchronous active-low reset
//   err_req in   an illegal write was accepted in this address phase
//   state   out  current sequencer state
//   hresp   out  1 while in either error cycle
// ---------------------------------------------------------------------------
module ahb_err_fsm
    import ahb_lite_slave_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       err_req,
    output err_state_e state,
    output logic       hresp
);

    err_state_e state_reg;
    err_state_e state_next;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ERR_IDLE: if (err_req) state_next = ERR_ONE;
            ERR_ONE:  state_next = ERR_TWO;
            ERR_TWO:  state_next = err_req ? ERR_ONE : ERR_IDLE;
            default:  state_next = ERR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ERR_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;
    assign hresp = (state_reg != ERR_IDLE);

endmodule

// File: rtl/ahb_lite_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_slave
// AHB-Lite slave exposing the control/status registers of a FIR filter.
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   hsel, haddr, hsize,     AHB-Lite address phase
//   htrans, hwrite
//   hwdata                  AHB-Lite write data (data phase)
//   hrdata, hresp           AHB-Lite read data / response (data phase)
//   sample_data, data_ready latched sample and one-cycle new-sample strobe
//   new_coefficient_set     coefficient reload request, cleared by coeff_loaded
//   coefficient_num         coefficient index requested by the loader
//   fir_coefficient         F[coefficient_num]
//   coeff_loaded            loader done
//   modwait, fir_out, err   filter status inputs
// ---------------------------------------------------------------------------
module ahb_lite_slave
    import ahb_lite_slave_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hsel,
    input  logic [3:0]  haddr,
    input  logic        hsize,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [15:0] hwdata,
    output logic [15:0] hrdata,
    output logic        hresp,
    output logic [15:0] sample_data,
    output logic        data_ready,
    output logic        new_coefficient_set,
    input  logic [1:0]  coefficient_num,
    output logic [15:0] fir_coefficient,
    input  logic        coeff_loaded,
    input  logic        modwait,
    input  logic [15:0] fir_out,
    input  logic        err
);

    err_state_e  err_state;
    logic        accept;
    logic        illegal_write;

    // Address-phase state carried into the data phase
    logic        dp_valid_reg;
    logic        dp_write_reg;
    logic        dp_size_reg;
    logic [3:0]  dp_addr_reg;

    logic [15:0] sample_reg;
    logic [15:0] coef_reg [NUM_COEF];
    logic        ncs_reg;
    logic        data_ready_reg;

    logic [3:0]  hw_addr;
    logic        wr_en;
    logic [15:0] reg_value;
    logic [15:0] wr_data;
    logic [NUM_COEF-1:0] coef_hit;
    logic        ncs_bit0_written;
    logic        ncs_set;
    logic        ncs_clr;

    // The master sees ERROR in ERR_ONE and is expected to cancel; anything it
    // presents then is dropped. From ERR_TWO onward a new transfer is taken.
    assign accept = hsel
                 && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                 && (err_state != ERR_ONE);

    assign illegal_write = accept && hwrite
                        && ({haddr[3:1], 1'b0} == ADDR_STATUS
                         || {haddr[3:1], 1'b0} == ADDR_RESULT);

    ahb_err_fsm u_err_fsm (
        .clk     (clk),
        .n_rst   (n_rst),
        .err_req (illegal_write),
        .state   (err_state),
        .hresp   (hresp)
    );

    // Illegal writes never open a data phase, so the target stays untouched.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_size_reg  <= 1'b0;
            dp_addr_reg  <= 4'd0;
        end else begin
            dp_valid_reg <= accept && !illegal_write;
            dp_write_reg <= hwrite;
            dp_size_reg  <= hsize;
            dp_addr_reg  <= haddr;
        end
    end

    assign hw_addr = {dp_addr_reg[3:1], 1'b0};
    assign wr_en   = dp_valid_reg && dp_write_reg;

    // Register readback, also the "old value" for byte-lane merging
    always_comb begin
        reg_value = 16'h0000;
        case (hw_addr)
            ADDR_STATUS: reg_value = {7'd0, err, 7'd0, modwait | ncs_reg};
            ADDR_RESULT: reg_value = fir_out;
            ADDR_SAMPLE: reg_value = sample_reg;
            ADDR_F0:     reg_value = coef_reg[0];
            ADDR_F1:     reg_value = coef_reg[1];
            ADDR_F2:     reg_value = coef_reg[2];
            ADDR_F3:     reg_value = coef_reg[3];
            ADDR_NCS:    reg_value = {15'd0, ncs_reg};
            default:     reg_value = 16'h0000;
        endcase
    end

    assign wr_data = merge_lanes(reg_value, hwdata, dp_size_reg, dp_addr_reg[0]);

    // A read immediately following a write to the same address needs no
    // bypass mux: the write lands on the same edge that opens the read's data
    // phase, so reg_value already holds the merged hwdata.
    assign hrdata = (dp_valid_reg && !dp_write_reg) ? reg_value : 16'h0000;

    generate
        for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_coef_hit
            assign coef_hit[gi] = wr_en && (hw_addr == ADDR_F0 + 4'(2 * gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                coef_reg[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NUM_COEF; i++) begin
                if (coef_hit[i]) begin
                    coef_reg[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sample_reg     <= 16'h0000;
            data_ready_reg <= 1'b0;
        end else begin
            data_ready_reg <= wr_en && (hw_addr == ADDR_SAMPLE);
            if (wr_en && (hw_addr == ADDR_SAMPLE)) begin
                sample_reg <= wr_data;
            end
        end
    end

    // Only a write touching the low byte affects bit0; an upper-byte write
    // leaves the request alone so coeff_loaded can still clear it.
    assign ncs_bit0_written = wr_en && (hw_addr == ADDR_NCS)
                           && (dp_size_reg || !dp_addr_reg[0]);
    assign ncs_set = ncs_bit0_written && hwdata[0];
    assign ncs_clr = (ncs_bit0_written && !hwdata[0]) || coeff_loaded;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ncs_reg <= 1'b0;
        end else if (ncs_set) begin
            ncs_reg <= 1'b1;
        end else if (ncs_clr) begin
            ncs_reg <= 1'b0;
        end
    end

    assign sample_data         = sample_reg;
    assign data_ready          = data_ready_reg;
    assign new_coefficient_set = ncs_reg;
    assign fir_coefficient     = coef_reg[coefficient_num];

endmodule

// File: tb/tb_ahb_lite_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_slave
// Self-checking bench for ahb_lite_slave: a table of single transfers plus
// hand-written pipelined sequences. Expected data-phase results are queued
// when the address phase is driven and popped when the data phase is sampled.
// ---------------------------------------------------------------------------
module tb_ahb_lite_slave;
    import ahb_lite_slave_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        hsel;
    logic [3:0]  haddr;
    logic        hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hresp;
    logic [15:0] sample_data;
    logic        data_ready;
    logic        new_coefficient_set;
    logic [1:0]  coefficient_num;
    logic [15:0] fir_coefficient;
    logic        coeff_loaded;
    logic        modwait;
    logic [15:0] fir_out;
    logic        err;

    ahb_lite_slave dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .hsel                (hsel),
        .haddr               (haddr),
        .hsize               (hsize),
        .htrans              (htrans),
        .hwrite              (hwrite),
        .hwdata              (hwdata),
        .hrdata              (hrdata),
        .hresp               (hresp),
        .sample_data         (sample_data),
        .data_ready          (data_ready),
        .new_coefficient_set (new_coefficient_set),
        .coefficient_num     (coefficient_num),
        .fir_coefficient     (fir_coefficient),
        .coeff_loaded        (coeff_loaded),
        .modwait             (modwait),
        .fir_out             (fir_out),
        .err                 (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int xfer_id = 0;

    typedef struct {
        int          id;
        logic        is_read;
        logic [15:0] rdata;
        logic        hresp;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [3:0]  addr;
        logic        size;
        logic        write;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];
    logic [15:0] exp_f[4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%04h", name, act);
        end
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
    endtask

    // Drive an address phase and queue what its data phase must show.
    task automatic addr_phase(input logic [3:0] a, input logic sz, input logic wr,
                              input logic [15:0] exp_rd, input logic exp_resp);
        exp_t e;
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = a;
        hsize  = sz;
        hwrite = wr;
        e.id      = xfer_id;
        e.is_read = !wr;
        e.rdata   = exp_rd;
        e.hresp   = exp_resp;
        sb_q.push_back(e);
        xfer_id++;
    endtask

    // Sample the current data phase against the oldest queued expectation.
    task automatic data_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got data phase, expected none queued");
        end else begin
            e = sb_q.pop_front();
            check($sformatf("xfer%0d hresp", e.id), {15'd0, hresp}, {15'd0, e.hresp});
            if (e.is_read) begin
                check($sformatf("xfer%0d hrdata", e.id), hrdata, e.rdata);
            end
        end
    endtask

    // One non-pipelined transfer: address phase, data phase, then settle.
    task automatic xfer(input logic [3:0] a, input logic sz, input logic wr,
                        input logic [15:0] wd, input logic [15:0] exp_rd,
                        input logic exp_resp);
        addr_phase(a, sz, wr, exp_rd, exp_resp);
        @(posedge clk); #1;
        idle_bus();
        hwdata = wd;
        @(negedge clk);
        data_check();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0;
        idle_bus();
        haddr = 4'h0;
        hsize = 1'b0;
        hwdata = 16'h0000;
        coefficient_num = 2'd0;
        coeff_loaded = 1'b0;
        modwait = 1'b0;
        fir_out = 16'h5A5A;
        err = 1'b1;

        // Register-map vectors, applied in order (later rows see earlier writes)
        vecs[0] = '{4'h6, 1'b1, 1'b1, 16'h34AB, 16'h0000};
        vecs[1] = '{4'h7, 1'b0, 1'b1, 16'h12FF, 16'h0000};
        vecs[2] = '{4'h6, 1'b1, 1'b0, 16'h0000, 16'h12AB};
        vecs[3] = '{4'hA, 1'b0, 1'b1, 16'hEE77, 16'h0000};
        vecs[4] = '{4'hB, 1'b0, 1'b0, 16'h0000, 16'h0077};
        vecs[5] = '{4'hC, 1'b1, 1'b1, 16'hBEEF, 16'h0000};
        vecs[6] = '{4'hC, 1'b1, 1'b0, 16'h0000, 16'hBEEF};
        vecs[7] = '{4'h2, 1'b1, 1'b0, 16'h0000, 16'h5A5A};
        vecs[8] = '{4'h0, 1'b1, 1'b0, 16'h0000, 16'h0100};
        vecs[9] = '{4'h1, 1'b0, 1'b0, 16'h0000, 16'h0100};
        exp_f[0] = 16'h12AB;
        exp_f[1] = 16'h0000;
        exp_f[2] = 16'h0077;
        exp_f[3] = 16'hBEEF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset hrdata", hrdata, 16'h0000);
        check("reset hresp", {15'd0, hresp}, 16'h0000);
        check("reset sample_data", sample_data, 16'h0000);
        check("reset data_ready", {15'd0, data_ready}, 16'h0000);
        check("reset ncs", {15'd0, new_coefficient_set}, 16'h0000);
        check("reset F0", fir_coefficient, 16'h0000);
        n_rst = 1'b1;

        // Table-driven single transfers
        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].addr, vecs[i].size, vecs[i].write, vecs[i].wdata, vecs[i].exp, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            coefficient_num = 2'(i);
            #1;
            check($sformatf("fir_coefficient F%0d", i), fir_coefficient, exp_f[i]);
        end
        modwait = 1'b1;
        xfer(4'h0, 1'b1, 1'b0, 16'h0000, 16'h0101, 1'b0);
        modwait = 1'b0;

        // Back-to-back sample writes: one strobe per write
        addr_phase(4'h4, 1'b1, 1'b1, 16'h0000, 1'b0);
        @(posedge clk); #1;
        hwdata = 16'hABCD;
        addr_phase(4'h4, 1'b1, 1'b1, 16'h0000, 1'b0);
        @(negedge clk);
        data_check();
        @(posedge clk); #1;
        check("sample after write1", sample_data, 16'hABCD);
        check("data_ready after write1", {15'd0, data_ready}, 16'h0001);
        idle_bus();
        hwdata = 16'h1357;
        @(negedge clk);
        data_check();
        @(posedge clk); #1;
        check("sample after write2", sample_data, 16'h1357);
        check("data_ready after write2", {15'd0, data_ready}, 16'h0001);
        @(posedge clk); #1;
        check("data_ready drops", {15'd0, data_ready}, 16'h0000);

        // Illegal write to result register: two ERROR cycles, then a read
        // presented during the second error cycle is honoured
        xfer_id = xfer_id;
        addr_phase(4'h2, 1'b1, 1'b1, 16'h0000, 1'b1);
        @(posedge clk); #1;
        idle_bus();
        hwdata = 16'h0001;
        @(negedge clk);
        data_check();
        @(posedge clk); #1;
        addr_phase(4'h6, 1'b1, 1'b0, 16'h12AB, 1'b0);
        @(negedge clk);
        check("error cycle2 hresp", {15'd0, hresp}, 16'h0001);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        data_check();
        @(posedge clk); #1;
        xfer(4'h2, 1'b1, 1'b0, 16'h0000, 16'h5A5A, 1'b0);

        // Coefficient reload request
        err = 1'b0;
        xfer(4'hE, 1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0);
        check("ncs set", {15'd0, new_coefficient_set}, 16'h0001);
        xfer(4'h0, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0);
        xfer(4'hE, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0);
        coeff_loaded = 1'b1;
        @(posedge clk); #1;
        coeff_loaded = 1'b0;
        check("ncs cleared", {15'd0, new_coefficient_set}, 16'h0000);
        addr_phase(4'hE, 1'b1, 1'b1, 16'h0000, 1'b0);
        @(posedge clk); #1;
        idle_bus();
        hwdata = 16'h0001;
        coeff_loaded = 1'b1;
        @(negedge clk);
        data_check();
        @(posedge clk); #1;
        coeff_loaded = 1'b0;
        check("ncs set wins", {15'd0, new_coefficient_set}, 16'h0001);

        // Write followed immediately by read of the same address
        addr_phase(4'h8, 1'b1, 1'b1, 16'h0000, 1'b0);
        @(posedge clk); #1;
        hwdata = 16'h5555;
        addr_phase(4'h8, 1'b1, 1'b0, 16'h5555, 1'b0);
        @(negedge clk);
        data_check();
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        data_check();
        @(posedge clk); #1;
        coefficient_num = 2'd1;
        #1;
        check("fir_coefficient F1 written", fir_coefficient, 16'h5555);

        // Reset pulse during a sample write data phase
        hsel = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr = 4'h4;
        hsize = 1'b1;
        hwrite = 1'b1;
        @(posedge clk); #1;
        idle_bus();
        hwdata = 16'h7777;
        #2;
        n_rst = 1'b0;
        #1;
        check("midreset sample_data", sample_data, 16'h0000);
        check("midreset data_ready", {15'd0, data_ready}, 16'h0000);
        check("midreset hrdata", hrdata, 16'h0000);
        check("midreset hresp", {15'd0, hresp}, 16'h0000);
        check("midreset ncs", {15'd0, new_coefficient_set}, 16'h0000);
        check("midreset F1", fir_coefficient, 16'h0000);
        @(posedge clk); #3;
        n_rst = 1'b1;
        check("aborted write sample_data", sample_data, 16'h0000);
        check("aborted write data_ready", {15'd0, data_ready}, 16'h0000);
        // First address phase after release must be honoured
        addr_phase(4'h4, 1'b1, 1'b1, 16'h0000, 1'b0);
        @(posedge clk); #1;
        idle_bus();
        hwdata = 16'h0042;
        @(negedge clk);
        data_check();
        @(posedge clk); #1;
        check("post-reset sample_data", sample_data, 16'h0042);
        check("post-reset data_ready", {15'd0, data_ready}, 16'h0001);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
